// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: ramps a registered PWM duty word toward a requested target.
// One step of up to step_i counts happens every period_i+1 enabled cycles.
// The duty saturates at the target and never wraps or underflows.
// A one-cycle done pulse is raised when the target is reached.
// An abort or reset discards the active ramp without a done pulse.
module pwm_ramp_ctrl #(
    parameter int WIDTH = 8,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             ena,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] target_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic [PER_W-1:0] period_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] duty_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DUTY_ZERO = {WIDTH{1'b0}};
    localparam logic [PER_W-1:0] CNT_ZERO = {PER_W{1'b0}};
    localparam logic [PER_W-1:0] CNT_ONE = {{(PER_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_s;
    logic             step_hit_s;
    logic [WIDTH:0]   up_sum_s;
    logic [WIDTH-1:0] down_gap_s;
    logic [WIDTH-1:0] stepped_s;

    assign req_ready_o = (state_q == ST_IDLE) && ena;
    assign accept_s    = req_valid_i && req_ready_o;
    assign step_hit_s  = (cnt_q == period_q);

    assign duty_o = duty_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

    // Candidate duty after one step, clamped to the target in either direction.
    always_comb begin
        up_sum_s   = {1'b0, duty_q} + {1'b0, step_q};
        down_gap_s = duty_q - target_q;
        stepped_s  = duty_q;
        if (duty_q < target_q) begin
            if (up_sum_s >= {1'b0, target_q}) begin
                stepped_s = target_q;
            end else begin
                stepped_s = up_sum_s[WIDTH-1:0];
            end
        end else begin
            if (step_q >= down_gap_s) begin
                stepped_s = target_q;
            end else begin
                stepped_s = duty_q - step_q;
            end
        end
    end

    // Next-state, datapath and output decode for the ramp sequencer.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        period_d = period_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    target_d = target_i;
                    step_d   = (step_i == DUTY_ZERO) ? STEP_ONE : step_i;
                    period_d = period_i;
                    cnt_d    = CNT_ZERO;
                    if (target_i == duty_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP: begin
                if (abort_i) begin
                    // Abort wins over a coincident step; duty keeps its value.
                    state_d = ST_IDLE;
                end else if (ena) begin
                    if (step_hit_s) begin
                        cnt_d  = CNT_ZERO;
                        duty_d = stepped_s;
                        if (stepped_s == target_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RAMP;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = ST_RAMP;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            duty_q   <= DUTY_ZERO;
            target_q <= DUTY_ZERO;
            step_q   <= STEP_ONE;
            period_q <= CNT_ZERO;
            cnt_q    <= CNT_ZERO;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            period_q <= period_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: a driver issues ramps and pushes the expected duty
// changes and done pulses into a queue; a negedge monitor pops and compares.
module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        ena = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  target_i = 8'd0;
    logic [7:0]  step_i = 8'd0;
    logic [15:0] period_i = 16'd0;
    logic        abort_i = 1'b0;
    logic [7:0]  duty_o;
    logic        busy_o;
    logic        done_o;

    pwm_ramp_ctrl #(.WIDTH(8), .PER_W(16)) dut (
        .clk(clk), .rst_i(rst_i), .ena(ena), .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o), .target_i(target_i), .step_i(step_i),
        .period_i(period_i), .abort_i(abort_i), .duty_o(duty_o),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit is_done;
        int val;
        int edge_n;
    } ev_t;
    ev_t exp_q[$];

    int total = 0;
    int bad = 0;
    int md = 0;           // reference duty after the last completed ramp
    bit mon_en = 1'b0;
    logic [7:0] prev_duty;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push(input bit is_done, input int val, input int edge_n);
        ev_t ev;
        ev.is_done = is_done;
        ev.val = val;
        ev.edge_n = edge_n;
        exp_q.push_back(ev);
    endfunction

    task automatic handle(input bit is_done, input int val);
        ev_t ev;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_event done=%0d duty=%0d cycle=%0d", is_done, val, cyc);
        end else begin
            ev = exp_q.pop_front();
            check("event_kind", int'(is_done), int'(ev.is_done));
            if (!is_done && !ev.is_done) check("duty_value", val, ev.val);
            check("event_edge", cyc, ev.edge_n);
        end
    endtask

    // Monitor: every duty change or done pulse must match the next expected event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (duty_o !== prev_duty) handle(1'b0, int'(duty_o));
            if (done_o === 1'b1) handle(1'b1, 0);
        end
        prev_duty = duty_o;
    end

    // Issue one ramp. f/len: ena low for edges T0+f+1..T0+f+len.
    // ab/rs: edge offset of abort / reset (0 = none).
    task automatic run_ramp(input int tgt, input int stp, input int per,
                            input int f, input int len, input int ab, input int rs);
        int t0;
        int d;
        int s;
        int en_cnt;
        int end_e;
        bit fin;
        bit frz;
        t0 = cyc + 1;
        d = md;
        s = (stp == 0) ? 1 : stp;
        en_cnt = 0;
        end_e = 1;
        fin = 1'b0;
        // Reference: walk edges after T0 and apply the ramp rules directly.
        if (tgt == d) begin
            push(1'b1, 0, t0);
            end_e = 1;
            fin = 1'b1;
        end
        for (int e = 1; e < 5000 && !fin; e++) begin
            frz = (e > f) && (e <= f + len);
            if (e == rs) begin
                if (d != 0) push(1'b0, 0, t0 + e);
                d = 0;
                end_e = e;
                fin = 1'b1;
            end else if (e == ab) begin
                end_e = e;
                fin = 1'b1;
            end else if (!frz) begin
                en_cnt++;
                if (en_cnt % (per + 1) == 0) begin
                    if (d < tgt) d = (d + s > tgt) ? tgt : d + s;
                    else d = (d - s < tgt) ? tgt : d - s;
                    push(1'b0, d, t0 + e);
                    if (d == tgt) begin
                        push(1'b1, 0, t0 + e);
                        end_e = e + 1;
                        fin = 1'b1;
                    end
                end
            end
        end
        md = d;
        // Drive the request for edge T0.
        check("ready_before_req", int'(req_ready_o), 1);
        req_valid_i = 1'b1;
        target_i = 8'(tgt);
        step_i = 8'(stp);
        period_i = 16'(per);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("busy_after_accept", int'(busy_o), 1);
        check("ready_after_accept", int'(req_ready_o), 0);
        for (int e = 1; e <= end_e; e++) begin
            ena = !((e > f) && (e <= f + len));
            abort_i = (e == ab);
            rst_i = (e == rs);
            target_i = 8'($urandom);
            step_i = 8'($urandom);
            period_i = 16'($urandom);
            @(negedge clk);
        end
        ena = 1'b1;
        abort_i = 1'b0;
        rst_i = 1'b0;
        #1;
        check("busy_after_ramp", int'(busy_o), 0);
        check("done_after_ramp", int'(done_o), 0);
        check("ready_after_ramp", int'(req_ready_o), 1);
        check("duty_after_ramp", int'(duty_o), md);
        @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tgt;
        int stp;
        int per;
        int f;
        int len;
        int ab;
        // Reset for two edges.
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_duty", int'(duty_o), 0);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        rst_i = 1'b0;
        #1;
        check("reset_ready", int'(req_ready_o), 1);
        ena = 1'b0;
        #1;
        check("ready_follows_ena", int'(req_ready_o), 0);
        ena = 1'b1;
        @(negedge clk);
        md = 0;
        mon_en = 1'b1;

        run_ramp(10, 3, 2, 0, 0, 0, 0);        // ramp up 3,6,9,10
        run_ramp(0, 4, 0, 0, 0, 0, 0);         // ramp down 6,2,0
        run_ramp(250, 255, 0, 0, 0, 0, 0);     // jump to 250
        run_ramp(255, 10, 0, 0, 0, 0, 0);      // saturate at 255
        run_ramp(0, 255, 0, 0, 0, 0, 0);       // back to 0
        run_ramp(100, 1, 0, 20, 5, 27, 0);     // freeze at 20, abort on a step
        check("abort_hold", int'(duty_o), 21);
        run_ramp(md, 7, 3, 0, 0, 0, 0);        // target equals duty
        run_ramp(25, 0, 1, 0, 0, 0, 0);        // step 0 acts as 1
        run_ramp(200, 5, 0, 0, 0, 0, 4);       // reset mid-ramp
        check("reset_mid_ramp_duty", int'(duty_o), 0);

        for (int i = 0; i < 25; i++) begin
            tgt = $urandom_range(0, 255);
            stp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 40);
            per = $urandom_range(0, 3);
            f = $urandom_range(0, 10);
            len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run_ramp(tgt, stp, per, f, len, ab, 0);
        end

        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the duty word width; matches the PWM duty input it drives.
REQ-002 SHALL have parameter PER_W, default 16, the step-period counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ena  input  1  enable; low freezes ramp progress and blocks request acceptance.
REQ-006 SHALL have port req_valid_i  input  1  ramp request valid.
REQ-007 SHALL have port req_ready_o  output  1  controller can accept a request.
REQ-008 SHALL have port target_i  input  WIDTH  target duty value.
REQ-009 SHALL have port step_i  input  WIDTH  duty increment per step; 0 means 1.
REQ-010 SHALL have port period_i  input  PER_W  extra cycles between steps; a step occurs every period_i+1 cycles.
REQ-011 SHALL have port abort_i  input  1  cancel the active ramp.
REQ-012 SHALL have port duty_o  output  WIDTH  registered duty value fed to the PWM duty input.
REQ-013 SHALL have port busy_o  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse when a ramp reaches its target.

Function
REQ-015 SHALL implement the states IDLE, RAMP and DONE.
REQ-016 req_ready_o SHALL equal (state==IDLE) AND ena, combinationally.
REQ-017 On an edge with req_valid_i AND req_ready_o (acceptance edge T0), SHALL latch target_i, step_i (0 replaced by 1) and period_i, and clear the period counter to 0.
REQ-018 At T0, if the latched target equals duty_o, SHALL go to DONE; otherwise SHALL go to RAMP.
REQ-019 In RAMP with ena=1, the period counter SHALL increment each cycle; on an edge where counter==period it SHALL reset to 0 and one step SHALL occur.
REQ-020 Step timing: the first step occurs at edge T0+period+1, and each later step every period+1 cycles.
REQ-021 Step up (duty<target): duty = min(duty+step, target), computed in WIDTH+1 bits with no wrap-around.
REQ-022 Step down (duty>target): duty = max(duty-step, target), with no underflow.
REQ-023 On the step edge where the new duty equals target, SHALL go to DONE.
REQ-024 In DONE, done_o SHALL be 1 for exactly that one cycle; the next edge SHALL return to IDLE unconditionally.
REQ-025 In RAMP with ena=0, the counter and duty_o SHALL hold and no state change SHALL occur, except on abort.
REQ-026 abort_i=1 in RAMP SHALL go to IDLE on that edge, regardless of ena.
REQ-027 On abort, duty_o SHALL hold its current value, done_o SHALL stay 0, and abort SHALL take priority over a coincident step.
REQ-028 abort_i SHALL be ignored in IDLE and DONE.
REQ-029 Inputs other than req_valid_i and abort_i SHALL be ignored outside the acceptance edge; request fields changing mid-ramp SHALL have no effect.
REQ-030 In IDLE, duty_o SHALL hold its last value; a new ramp SHALL start from the current duty_o.

Reset
REQ-031 With rst_i=1 at a clock edge: state SHALL become IDLE, duty_o 0, counter 0, done_o 0 and busy_o 0; rst_i SHALL override all other inputs, including a request in flight.
REQ-032 Reset asserted mid-ramp SHALL discard the ramp with no done pulse.
REQ-033 After reset, req_ready_o SHALL follow ena.

Verification
REQ-034 Reset check: assert rst_i for 2 cycles -> duty_o=0, busy_o=0, done_o=0; req_ready_o=1 with ena=1.
REQ-035 Ramp up: duty 0, target 10, step 3, period 2 -> duty_o=3,6,9,10 after edges T0+3, +6, +9, +12; done_o high in the cycle after T0+12; busy_o low after T0+13.
REQ-036 Ramp down, fast: from duty 10, target 0, step 4, period 0 -> duty_o=6,2,0 after edges T0+1,+2,+3; no underflow; single done pulse.
REQ-037 Saturation: duty 250, target 255, step 10, period 0 -> duty_o=255 after T0+1 (no wrap to 4), then done.
REQ-038 Freeze and abort: from duty 0, ramp to target 100, step 1, period 0; drop ena for 5 cycles at duty 20 -> duty_o holds 20. Then raise ena and assert abort_i coincident with a step -> IDLE, duty_o stays at its pre-edge value, no done_o.
REQ-039 Degenerate cases: target equal to duty_o -> done pulse at T0+1 with duty unchanged. step_i=0 behaves as step 1. rst_i mid-ramp -> duty_o=0, no done_o.
